pipeline_hazard_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage RV32 pipeline (F/D/E/M/W).

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctrl_fwd_sel.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the RV32 pipeline hazard controller: forwarding selects,
// debug FSM states and the bundle of pipeline stall/flush controls.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10,
        ST_STEP   = 2'b11
    } dbg_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic flush_d;
        logic flush_e;
    } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Forward select for one E-stage ALU operand; the M stage has priority over W
// because it holds the younger result.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output fwd_sel_t          sel
);

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    logic hit_m;
    logic hit_w;

    assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs);
    assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs);

    assign sel = hit_m ? FWD_MEM : (hit_w ? FWD_WB : FWD_RF);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: forwarding,
// load-use stalls, branch flushes, debug run/halt/step FSM and stall counter.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              resume_req,
    input  logic [REG_AW-1:0] RS1_D,
    input  logic [REG_AW-1:0] RS2_D,
    input  logic [REG_AW-1:0] RS1_E,
    input  logic [REG_AW-1:0] RS2_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic              ResultSrcE,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RD_M,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RD_W,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (RS1_E),
        .rd_m        (RD_M),
        .reg_write_m (RegWriteM),
        .rd_w        (RD_W),
        .reg_write_w (RegWriteW),
        .sel         (fwd_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (RS2_E),
        .rd_m        (RD_M),
        .reg_write_m (RegWriteM),
        .rd_w        (RD_W),
        .reg_write_w (RegWriteW),
        .sel         (fwd_b)
    );

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    // A taken branch squashes the dependent instruction, so no stall is needed then.
    logic load_use;
    logic ld_stall;

    assign load_use = ResultSrcE && (RD_E != '0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
    assign ld_stall = load_use && !PCSrcE;

    dbg_state_t       state;
    dbg_state_t       state_nxt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_cnt_nxt;
    ctrl_t            ctrl;

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        ctrl.stall_f = ld_stall;
        ctrl.stall_d = ld_stall;
        ctrl.flush_d = PCSrcE;
        ctrl.flush_e = ld_stall || PCSrcE;
        case (state)
            ST_DRAIN: begin
                ctrl.stall_f = !PCSrcE;
                ctrl.flush_d = !ld_stall || PCSrcE;
            end
            ST_HALTED: begin
                ctrl.stall_f = 1'b1;
                ctrl.stall_d = 1'b1;
                ctrl.flush_d = 1'b0;
                ctrl.flush_e = 1'b1;
            end
            default: ;
        endcase
    end

    assign StallF = ctrl.stall_f;
    assign StallD = ctrl.stall_d;
    assign FlushD = ctrl.flush_d;
    assign FlushE = ctrl.flush_e;
    assign halted = (state == ST_HALTED);

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            ST_RUN: begin
                if (halt_req) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                // Only real bubbles count towards an empty pipeline.
                if (PCSrcE) begin
                    drain_cnt_nxt = DRAIN_LOAD;
                end else if (!ld_stall) begin
                    drain_cnt_nxt = drain_cnt - 1'b1;
                    if (drain_cnt == DRAIN_W'(1)) begin
                        state_nxt = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                if (resume_req) begin
                    state_nxt = ST_RUN;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                state_nxt     = ST_DRAIN;
                drain_cnt_nxt = DRAIN_LOAD;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (ld_stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed debug/hazard scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam int DRAIN = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          halt_req, step_req, resume_req;
    logic [AW-1:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic          ResultSrcE, PCSrcE, RegWriteM, RegWriteW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, FlushD, FlushE, halted;
    logic [CW-1:0] stall_count;

    pipeline_hazard_ctrl #(.REG_AW(AW), .DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RD_E(RD_E), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef enum {M_RUN, M_DRAIN, M_HALT, M_STEP} mode_t;
    mode_t m_mode;
    int    m_left;
    int    m_cnt;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int fwd_exp(input logic [AW-1:0] rs);
        if (RegWriteM && RD_M != 0 && RD_M == rs) return 2;
        if (RegWriteW && RD_W != 0 && RD_W == rs) return 1;
        return 0;
    endfunction

    function automatic bit ld_exp();
        return ResultSrcE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D) && !PCSrcE;
    endfunction

    task automatic model_reset();
        m_mode = M_RUN;
        m_left = 0;
        m_cnt  = 0;
    endtask

    task automatic model_clock();
        bit ld;
        ld = ld_exp();
        if (!rst) begin
            model_reset();
            return;
        end
        if (ld && m_cnt < CNT_MAX) m_cnt++;
        case (m_mode)
            M_RUN:   if (halt_req) begin m_mode = M_DRAIN; m_left = DRAIN; end
            M_DRAIN: begin
                if (PCSrcE) m_left = DRAIN;
                else if (!ld) begin
                    m_left--;
                    if (m_left == 0) m_mode = M_HALT;
                end
            end
            M_HALT:  if (resume_req) m_mode = M_RUN; else if (step_req) m_mode = M_STEP;
            M_STEP:  begin m_mode = M_DRAIN; m_left = DRAIN; end
        endcase
    endtask

    task automatic check_all(input string tag);
        int sf, sd, fd, fe;
        bit ld;
        ld = ld_exp();
        case (m_mode)
            M_DRAIN: begin sf = !PCSrcE; sd = ld; fd = !ld || PCSrcE; fe = ld || PCSrcE; end
            M_HALT:  begin sf = 1; sd = 1; fd = 0; fe = 1; end
            default: begin sf = ld; sd = ld; fd = PCSrcE; fe = ld || PCSrcE; end
        endcase
        check({tag, ".fwd_a"}, 32'(ForwardAE), fwd_exp(RS1_E));
        check({tag, ".fwd_b"}, 32'(ForwardBE), fwd_exp(RS2_E));
        check({tag, ".stall_f"}, 32'(StallF), sf);
        check({tag, ".stall_d"}, 32'(StallD), sd);
        check({tag, ".flush_d"}, 32'(FlushD), fd);
        check({tag, ".flush_e"}, 32'(FlushE), fe);
        check({tag, ".halted"}, 32'(halted), (m_mode == M_HALT) ? 1 : 0);
        check({tag, ".stall_count"}, 32'(stall_count), m_cnt);
    endtask

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic tick(input string tag);
        #1;
        if (!rst) model_reset();
        check_all(tag);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        halt_req = 0; step_req = 0; resume_req = 0;
        RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0;
        ResultSrcE = 0; PCSrcE = 0;
        RD_M = 0; RegWriteM = 0; RD_W = 0; RegWriteW = 0;
    endtask

    task automatic set_load_use();
        ResultSrcE = 1; RD_E = 7; RS2_D = 7;
    endtask

    initial begin
        clr_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        tick("reset");
        rst = 1;

        // Forwarding priority and x0 suppression
        RS1_E = 5; RD_M = 5; RegWriteM = 1; RD_W = 5; RegWriteW = 1;
        #1 check("fwd.mem", 32'(ForwardAE), 2);
        RegWriteM = 0;
        #1 check("fwd.wb", 32'(ForwardAE), 1);
        RD_M = 0; RD_W = 0;
        tick("fwd.rf");
        RS2_E = 3; RD_M = 3; RegWriteM = 1;
        tick("fwd.b_mem");

        // Load-use stall, then load-use masked by a taken branch
        clr_inputs();
        set_load_use();
        #1 check("lu.stall_f", 32'(StallF), 1);
        repeat (3) tick("lu");
        PCSrcE = 1;
        #1 check("lu_br.stall_f", 32'(StallF), 0);
        repeat (2) tick("lu_br");

        // Halt from RUN with no hazards: three drain cycles then HALTED
        clr_inputs();
        halt_req = 1;
        tick("halt.req");
        halt_req = 0;
        repeat (DRAIN) tick("halt.drain");
        #1 check("halt.halted", 32'(halted), 1);
        tick("halt.hold");

        // Single step, drain again, then simultaneous step+resume
        step_req = 1;
        tick("step.req");
        step_req = 0;
        #1 check("step.stall_f", 32'(StallF), 0);
        tick("step.run");
        repeat (DRAIN) tick("step.drain");
        #1 check("step.halted", 32'(halted), 1);
        step_req = 1; resume_req = 1;
        tick("resume.both");
        clr_inputs();
        #1 check("resume.halted", 32'(halted), 0);
        tick("resume.run");

        // Taken branch in the second drain cycle reloads the counter
        halt_req = 1;
        tick("br.req");
        halt_req = 0;
        tick("br.drain1");
        PCSrcE = 1;
        tick("br.drain2");
        PCSrcE = 0;
        repeat (DRAIN) tick("br.drain");
        #1 check("br.halted", 32'(halted), 1);
        resume_req = 1;
        tick("br.resume");
        clr_inputs();

        // Stall counter saturation
        set_load_use();
        repeat (CNT_MAX + 4) tick("sat");
        #1 check("sat.hold", 32'(stall_count), CNT_MAX);

        // Asynchronous reset in the middle of DRAIN
        clr_inputs();
        halt_req = 1;
        tick("rst.req");
        halt_req = 0;
        tick("rst.drain");
        rst = 0;
        #1 check("rst.halted", 32'(halted), 0);
        check("rst.count", 32'(stall_count), 0);
        check("rst.stall_f", 32'(StallF), 0);
        tick("rst.low");
        rst = 1;
        tick("rst.run");

        // Randomized traffic over a small register window to provoke matches
        for (int i = 0; i < 1500; i++) begin
            halt_req   = ($urandom_range(0, 9) == 0);
            step_req   = ($urandom_range(0, 3) == 0);
            resume_req = ($urandom_range(0, 5) == 0);
            RS1_D = AW'($urandom_range(0, 3));
            RS2_D = AW'($urandom_range(0, 3));
            RS1_E = AW'($urandom_range(0, 3));
            RS2_E = AW'($urandom_range(0, 3));
            RD_E  = AW'($urandom_range(0, 3));
            RD_M  = AW'($urandom_range(0, 3));
            RD_W  = AW'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) RS1_E = AW'($urandom);
            ResultSrcE = ($urandom_range(0, 1) == 0);
            PCSrcE     = ($urandom_range(0, 4) == 0);
            RegWriteM  = ($urandom_range(0, 3) != 0);
            RegWriteW  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) != 0);
            tick("rand");
            rst = 1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
